// File: rtl/counter_cmd_seq.sv
// Command sequencer for the 4-bit up/down loadable counter.
// Buffers {data, dir, dwell} commands in a small FIFO. Each command is replayed as
// a one-cycle load strobe with data/up_dwn. The sequencer then holds for dwell
// cycles and pulses cmd_done on the first idle cycle after the command.
//
// Ports:
//   clk        - clock, all logic on rising edge
//   reset      - synchronous active-low reset
//   abort      - synchronous flush of FIFO and FSM (data/up_dwn retained)
//   cmd_valid  - command offered
//   cmd_ready  - FIFO can accept this cycle
//   cmd_data   - value to load into counter
//   cmd_dir    - direction after load (1 = up)
//   cmd_dwell  - cycles to hold after load before next command
//   load       - counter load strobe (registered)
//   data       - counter load value (registered)
//   up_dwn     - counter direction (registered)
//   cmd_done   - one-cycle pulse when a command's dwell completes
//   busy       - FSM not idle or FIFO non-empty
//   fifo_count - current FIFO occupancy
module counter_cmd_seq #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          abort,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DATA_W-1:0]             cmd_data,
  input  logic                          cmd_dir,
  input  logic [DWELL_W-1:0]            cmd_dwell,
  output logic                          load,
  output logic [DATA_W-1:0]             data,
  output logic                          up_dwn,
  output logic                          cmd_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = DATA_W + 1 + DWELL_W;
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDwell} state_e;

  logic [EntryW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               load_q, load_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               up_dwn_q, up_dwn_d;
  logic               done_q, done_d;

  logic               push, pop;
  logic [EntryW-1:0]  head;
  logic [DATA_W-1:0]  head_data;
  logic               head_dir;
  logic [DWELL_W-1:0] head_dwell;

  // Ready depends only on registered count plus the abort/reset inputs.
  assign cmd_ready = (count_q != FullCount) && !abort && reset;
  assign push      = cmd_valid && cmd_ready;
  // Registered count: a command pushed into an empty FIFO is not popped on the same edge.
  assign pop       = (state_q == StIdle) && (count_q != '0);

  assign head = mem_q[rd_ptr_q];
  assign {head_data, head_dir, head_dwell} = head;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StLoad;
      StLoad:  state_d = (dwell_cnt_q == '0) ? StIdle : StDwell;
      StDwell: if (dwell_cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values; data and up_dwn only change on a pop.
  always_comb begin
    load_d      = 1'b0;
    done_d      = 1'b0;
    data_d      = data_q;
    up_dwn_d    = up_dwn_q;
    dwell_cnt_d = dwell_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          load_d      = 1'b1;
          data_d      = head_data;
          up_dwn_d    = head_dir;
          dwell_cnt_d = head_dwell;
        end
      end
      StLoad, StDwell: begin
        if (dwell_cnt_q == '0) begin
          done_d = 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // State register: reset > abort > normal operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dwell_cnt_q <= '0;
      load_q      <= 1'b0;
      data_q      <= '0;
      up_dwn_q    <= 1'b1;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q  <= StIdle;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dwell_cnt_q <= dwell_cnt_d;
      load_q      <= load_d;
      data_q      <= data_d;
      up_dwn_q    <= up_dwn_d;
      done_q      <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; push is already gated by reset and abort.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_data, cmd_dir, cmd_dwell};
  end

  assign load       = load_q;
  assign data       = data_q;
  assign up_dwn     = up_dwn_q;
  assign cmd_done   = done_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_counter_cmd_seq.sv
module tb_counter_cmd_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       abort = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = 4'h0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_dwell = 8'h0;
  logic       load;
  logic [3:0] data;
  logic       up_dwn;
  logic       cmd_done;
  logic       busy;
  logic [2:0] fifo_count;

  counter_cmd_seq #(
    .DATA_W     (4),
    .DWELL_W    (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .abort      (abort),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_dwell  (cmd_dwell),
    .load       (load),
    .data       (data),
    .up_dwn     (up_dwn),
    .cmd_done   (cmd_done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       dir;
    logic [7:0] dwell;
  } cmd_t;

  typedef struct {
    logic [3:0] d;
    logic       dir;
    int         c;
  } obs_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  cmd_t exp_q[$];
  obs_t obs_q[$];
  int   done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record load strobes and done pulses with the cycle they occupy.
  always @(negedge clk) begin
    if (load === 1'b1) obs_q.push_back('{data, up_dwn, cyc});
    if (cmd_done === 1'b1) done_q.push_back(cyc);
  end

  task automatic push_cmd(input logic [3:0] d, input logic dir, input logic [7:0] dw,
                          output int acc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_dwell = dw;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    exp_q.push_back('{d, dir, dw});
    cmd_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int i = 0;
    while (obs_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (obs_q.size() < n) begin
      miscompares++;
      $display("FAIL load_timeout: loads seen=%0d, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int i = 0;
    while (done_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (done_q.size() < n) begin
      miscompares++;
      $display("FAIL done_timeout: done pulses=%0d, required %0d", done_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = 4'h9;
    cmd_dwell = 8'd3;
    repeat (4) begin
      @(posedge clk); #1;
      vectors++;
      if (cmd_ready !== 1'b0 || load !== 1'b0 || data !== 4'h0 || up_dwn !== 1'b1 ||
          fifo_count !== 3'd0 || busy !== 1'b0 || cmd_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: ready=%b load=%b data=%h up_dwn=%b count=%0d busy=%b done=%b, required 0 0 0 1 0 0 0",
                 cmd_ready, load, data, up_dwn, fifo_count, busy, cmd_done);
      end
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b count=%0d, required 1 0", cmd_ready, fifo_count);
    end
    obs_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single();
    int acc;
    obs_t o;
    cmd_t e;
    push_cmd(4'h0, 1'b1, 8'd4, acc);
    wait_obs(1, 20);
    wait_done(1, 30);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 1) begin
      miscompares++;
      $display("FAIL single_pulses: load cycles=%0d, required 1", obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.dir !== e.dir) begin
        miscompares++;
        $display("FAIL single_data: data=%h up_dwn=%b, required %h %b", o.d, o.dir, e.d, e.dir);
      end
      vectors++;
      if (o.c !== acc + 1) begin
        miscompares++;
        $display("FAIL single_latency: load cycle=%0d, required %0d", o.c, acc + 1);
      end
      if (done_q.size() > 0) begin
        vectors++;
        if (done_q[0] !== o.c + int'(e.dwell) + 1) begin
          miscompares++;
          $display("FAIL single_done: done cycle=%0d, required %0d", done_q[0],
                   o.c + int'(e.dwell) + 1);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: busy=%b load=%b, required 0 0", busy, load);
    end
    obs_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, acc2, prev_c, prev_dw, dc;
    obs_t o;
    cmd_t e;
    push_cmd(4'hF, 1'b0, 8'd4, acc0);
    push_cmd(4'h4, 1'b1, 8'd2, acc1);
    push_cmd(4'h2, 1'b1, 8'd0, acc2);
    wait_obs(3, 60);
    wait_done(3, 60);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 3 || done_q.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_counts: loads=%0d dones=%0d, required 3 3", obs_q.size(), done_q.size());
    end
    vectors++;
    if (obs_q.size() > 0 && obs_q[0].c !== acc0 + 1) begin
      miscompares++;
      $display("FAIL b2b_latency: load cycle=%0d, required %0d", obs_q[0].c, acc0 + 1);
    end
    prev_c = 0;
    prev_dw = 0;
    for (int i = 0; i < 3; i++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0 || done_q.size() == 0) break;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      dc = done_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.dir !== e.dir) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: data=%h up_dwn=%b, required %h %b", i, o.d, o.dir, e.d, e.dir);
      end
      if (i > 0) begin
        vectors++;
        if (o.c - prev_c !== prev_dw + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: spacing=%0d, required %0d", i, o.c - prev_c, prev_dw + 2);
        end
      end
      vectors++;
      if (dc !== o.c + int'(e.dwell) + 1) begin
        miscompares++;
        $display("FAIL b2b_done[%0d]: done cycle=%0d, required %0d", i, dc, o.c + int'(e.dwell) + 1);
      end
      prev_c = o.c;
      prev_dw = int'(e.dwell);
    end
    obs_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_full_fifo();
    int acc, acc_f, done_a, dc;
    obs_t o;
    cmd_t e;
    push_cmd(4'h1, 1'b1, 8'd20, acc);
    wait_obs(1, 10);
    push_cmd(4'h2, 1'b0, 8'd0, acc);
    push_cmd(4'h3, 1'b1, 8'd1, acc);
    push_cmd(4'h4, 1'b0, 8'd0, acc);
    push_cmd(4'h5, 1'b1, 8'd2, acc);
    vectors++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: count=%0d ready=%b, required 4 0", fifo_count, cmd_ready);
    end
    push_cmd(4'h6, 1'b0, 8'd1, acc_f);
    wait_obs(6, 150);
    wait_done(6, 150);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 6 || done_q.size() !== 6) begin
      miscompares++;
      $display("FAIL full_counts: loads=%0d dones=%0d, required 6 6", obs_q.size(), done_q.size());
    end
    done_a = -1;
    for (int i = 0; i < 6; i++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0 || done_q.size() == 0) break;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      dc = done_q.pop_front();
      if (i == 0) done_a = dc;
      vectors++;
      if (o.d !== e.d || o.dir !== e.dir) begin
        miscompares++;
        $display("FAIL full_data[%0d]: data=%h up_dwn=%b, required %h %b", i, o.d, o.dir, e.d, e.dir);
      end
      vectors++;
      if (dc !== o.c + int'(e.dwell) + 1) begin
        miscompares++;
        $display("FAIL full_done[%0d]: done cycle=%0d, required %0d", i, dc, o.c + int'(e.dwell) + 1);
      end
    end
    // Fifth queued command enters on the edge after the first pop frees a slot.
    vectors++;
    if (acc_f !== done_a + 2) begin
      miscompares++;
      $display("FAIL full_accept: accept cycle=%0d, required %0d", acc_f, done_a + 2);
    end
    obs_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_abort();
    int acc;
    obs_t o;
    cmd_t e;
    push_cmd(4'h6, 1'b0, 8'd10, acc);
    wait_obs(1, 10);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.dir !== e.dir) begin
        miscompares++;
        $display("FAIL abort_first: data=%h up_dwn=%b, required %h %b", o.d, o.dir, e.d, e.dir);
      end
    end
    push_cmd(4'h7, 1'b1, 8'd1, acc);
    push_cmd(4'h8, 1'b1, 8'd1, acc);
    push_cmd(4'h9, 1'b0, 8'd1, acc);
    abort = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready: cmd_ready=%b, required 0", cmd_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if (fifo_count !== 3'd0 || load !== 1'b0 || cmd_done !== 1'b0 || busy !== 1'b0 ||
        data !== 4'h6 || up_dwn !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_flush: count=%0d load=%b done=%b busy=%b data=%h up_dwn=%b, required 0 0 0 0 6 0",
               fifo_count, load, cmd_done, busy, data, up_dwn);
    end
    exp_q.delete();
    repeat (15) @(negedge clk);
    vectors++;
    if (done_q.size() !== 0 || obs_q.size() !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: dones=%0d loads=%0d, required 0 0", done_q.size(), obs_q.size());
    end
    done_q.delete();
    obs_q.delete();
    push_cmd(4'hA, 1'b1, 8'd1, acc);
    wait_obs(1, 10);
    wait_done(1, 10);
    if (obs_q.size() > 0 && exp_q.size() > 0 && done_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.dir !== e.dir || o.c !== acc + 1 || done_q[0] !== o.c + int'(e.dwell) + 1) begin
        miscompares++;
        $display("FAIL abort_resume: data=%h dir=%b load=%0d done=%0d, required %h %b %0d %0d",
                 o.d, o.dir, o.c, done_q[0], e.d, e.dir, acc + 1, o.c + int'(e.dwell) + 1);
      end
    end
    obs_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int acc;
    obs_t o;
    cmd_t e;
    push_cmd(4'hB, 1'b1, 8'd10, acc);
    wait_obs(1, 10);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.dir !== e.dir) begin
        miscompares++;
        $display("FAIL rst_mid_load: data=%h up_dwn=%b, required %h %b", o.d, o.dir, e.d, e.dir);
      end
    end
    push_cmd(4'hC, 1'b0, 8'd1, acc);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_ready: cmd_ready=%b, required 0", cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (load !== 1'b0 || data !== 4'h0 || up_dwn !== 1'b1 || cmd_done !== 1'b0 ||
        fifo_count !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_state: load=%b data=%h up_dwn=%b done=%b count=%0d busy=%b, required 0 0 1 0 0 0",
               load, data, up_dwn, cmd_done, fifo_count, busy);
    end
    reset = 1'b1;
    exp_q.delete();
    repeat (15) @(negedge clk);
    vectors++;
    if (done_q.size() !== 0 || obs_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: dones=%0d loads=%0d busy=%b, required 0 0 0",
               done_q.size(), obs_q.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
